dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and the debug/loader port (DBG).
- Handles sub-word access for the CPU port:
  - turns address plus size into the memory word address, byte enables and lane-aligned write data;
  - extracts and sign- or zero-extends load data;
  - flags misaligned accesses.
- Sits between the MEM stage and the data memory. The data memory has a combinational read and a level-sensitive write gated by its write enable.

Parameters:
- AW, 10, word-address width driven to memory (byte address bits AW+1:2).
- STARVE_MAX, 4, consecutive denied DBG cycles before DBG is forced to win.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, level, held until cpu_gnt
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW+2  byte address
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- cpu_sext  in  1  sign-extend load (lb/lh)
- cpu_wdata  in  32  store data, right-justified
- cpu_gnt  out  1  access accepted this cycle
- cpu_rvalid  out  1  response valid, one cycle after an accepted access
- cpu_rdata  out  32  extended load data
- cpu_err  out  1  misaligned, valid with cpu_rvalid
- dbg_req  in  1  DBG request, word access only
- dbg_we  in  1  DBG store
- dbg_addr  in  AW  word address
- dbg_wdata  in  32  DBG store data
- dbg_gnt  out  1  DBG accepted this cycle
- dbg_rvalid  out  1  DBG response valid
- dbg_rdata  out  32  DBG load word
- dm_we  out  1  memory write enable
- dm_addr  out  AW  memory word address
- dm_be  out  4  byte enables
- dm_din  out  32  lane-aligned write data
- dm_dout  in  32  memory read data

Behaviour:
- Reset (rstn low, asynchronous):
  - starvation counter, response registers and grant state cleared;
  - cpu_rvalid, dbg_rvalid, cpu_err = 0; cpu_rdata, dbg_rdata = 0.
  - Combinational outputs are forced low while rstn is low: dm_we, dm_be, cpu_gnt, dbg_gnt = 0.
- Arbitration (combinational each cycle, at most one grant):
  - Default CPU priority.
  - Starvation counter increments on each cycle with dbg_req=1 and dbg_gnt=0, saturating at STARVE_MAX.
  - When the counter equals STARVE_MAX and dbg_req=1, DBG wins over CPU.
  - Counter clears on dbg_gnt, or when dbg_req=0.
- Access timing:
  - A granted access completes in the grant cycle: memory is driven that cycle.
  - Response registers are loaded at the closing edge; rvalid is high for exactly one cycle after.
  - Back-to-back grants every cycle are allowed.
- CPU lane mapping, with off = cpu_addr[1:0]:
  - dm_addr = cpu_addr[AW+1:2].
  - byte: be = 1<<off; din = wdata[7:0] replicated to all lanes.
  - half: off=0 gives be=0011, off=2 gives be=1100; din = wdata[15:0] replicated to both halves.
  - word: be = 1111; din = wdata.
- Misaligned CPU access (half with off[0]=1, word with off≠0, size=11):
  - cpu_gnt still asserted, so the request is consumed;
  - dm_we = 0, dm_be = 0000;
  - next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
- Loads:
  - off, size and sext are registered with the grant.
  - The selected byte/half of the registered dm_dout is extended to 32 bits: sign-extend when sext=1, zero-extend otherwise; word passes through.
- DBG accesses: be = 1111, dm_addr = dbg_addr, dm_din = dbg_wdata.
- dm_we = granted & we & ~misaligned. With no grant: dm_we=0, dm_be=0000, dm_addr/dm_din hold the CPU-path value (don't care).
- Requests deasserting without a grant are dropped silently; no state is kept.
- Reset mid-access: the pending rvalid is lost. A store whose grant cycle overlaps reset assertion does not write, because dm_we is gated by rstn.

Decomposition:
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - a be/lane-mapping function;
  - a load-extract function.
- One sub-module is natural: dm_lane_align, holding the combinational store alignment and load extraction (size, offset, sext). It is reused by any future cache fill path.

Test Plan:
1. Reset, then CPU sb addr 0x005 data 0x000000AB -> in the grant cycle dm_addr=1, dm_be=0010, dm_din=0xABABABAB, dm_we=1; next cycle cpu_rvalid=1, cpu_err=0.
2. With memory word 1 = 0x12345680: lb 0x004 sext=1 -> cpu_rdata=0xFFFFFF80; lbu 0x004 -> 0x00000080; lhu 0x006 -> 0x00001234; lh 0x006 -> 0x00001234.
3. lw 0x002 and sh 0x003 -> cpu_gnt=1, dm_we=0, dm_be=0000; next cycle cpu_err=1, cpu_rdata=0; memory unchanged.
4. cpu_req and dbg_req held high continuously -> CPU granted 4 cycles, DBG granted on the 5th, counter cleared, pattern repeats; never two grants in one cycle.
5. DBG sw word 3 = 0xDEADBEEF then DBG lw word 3 -> dbg_rvalid one cycle after each grant, dbg_rdata=0xDEADBEEF.
6. Pull rstn low in the grant cycle of a CPU sw -> dm_we drops immediately, no rvalid follows, memory unchanged; first access after release proceeds normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Access-size encodings and sub-word lane helpers shared by
//                the data-memory path.
//  Revision    : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size 2'b11 is reserved and always reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        lane_be = 4'b0000;
        if (!is_misaligned(size, off)) begin
            case (size)
                SZ_BYTE: lane_be = 4'b0001 << off;
                SZ_HALF: lane_be = off[1] ? 4'b1100 : 4'b0011;
                SZ_WORD: lane_be = 4'b1111;
                default: lane_be = 4'b0000;
            endcase
        end
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sext,
                                                 input logic [31:0] word);
        logic [7:0]  w_b;
        logic [15:0] w_h;
        case (off)
            2'd0:    w_b = word[7:0];
            2'd1:    w_b = word[15:8];
            2'd2:    w_b = word[23:16];
            default: w_b = word[31:24];
        endcase
        w_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extract = {{24{sext & w_b[7]}}, w_b};
            SZ_HALF: load_extract = {{16{sext & w_h[15]}}, w_h};
            SZ_WORD: load_extract = word;
            default: load_extract = 32'h0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lane_align
//  Description : Combinational store lane alignment and load extraction.
//  Revision    : 1.0
// ============================================================================
module dm_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_din,
    output logic        o_st_misaligned,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_sext,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    always_comb begin
        o_st_misaligned = is_misaligned(i_st_size, i_st_off);
        o_st_be         = lane_be(i_st_size, i_st_off);
        case (i_st_size)
            SZ_BYTE: o_st_din = {4{i_st_wdata[7:0]}};
            SZ_HALF: o_st_din = {2{i_st_wdata[15:0]}};
            default: o_st_din = i_st_wdata;
        endcase
        o_ld_data = load_extract(i_ld_size, i_ld_off, i_ld_sext, i_ld_word);
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : CPU/debug arbiter for the single-port data memory with
//                sub-word lane handling on the CPU side.
//  Revision    : 1.0
// ============================================================================
module dm_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW+1:0] cpu_addr,
    input  logic [1:0]    cpu_size,
    input  logic          cpu_sext,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    localparam int           c_CW        = $clog2(STARVE_MAX + 1);
    localparam logic [c_CW-1:0] c_STARVE = c_CW'(STARVE_MAX);

    logic [c_CW-1:0] r_starve;
    logic            w_starved;
    logic [3:0]      w_cpu_be;
    logic [31:0]     w_cpu_din;
    logic            w_cpu_mis;

    logic            r_cpu_rvalid;
    logic            r_cpu_err;
    logic [1:0]      r_ld_size;
    logic [1:0]      r_ld_off;
    logic            r_ld_sext;
    logic [31:0]     r_cpu_word;
    logic            r_dbg_rvalid;
    logic [31:0]     r_dbg_rdata;

    dm_lane_align u_align (
        .i_st_size       (cpu_size),
        .i_st_off        (cpu_addr[1:0]),
        .i_st_wdata      (cpu_wdata),
        .o_st_be         (w_cpu_be),
        .o_st_din        (w_cpu_din),
        .o_st_misaligned (w_cpu_mis),
        .i_ld_size       (r_ld_size),
        .i_ld_off        (r_ld_off),
        .i_ld_sext       (r_ld_sext),
        .i_ld_word       (r_cpu_word),
        .o_ld_data       (cpu_rdata)
    );

    // Grants are gated by rstn so a store overlapping reset assertion never writes.
    always_comb begin
        w_starved = dbg_req && (r_starve == c_STARVE);
        cpu_gnt   = rstn & cpu_req & ~w_starved;
        dbg_gnt   = rstn & dbg_req & (w_starved | ~cpu_req);
        dm_addr   = dbg_gnt ? dbg_addr  : cpu_addr[AW+1:2];
        dm_din    = dbg_gnt ? dbg_wdata : w_cpu_din;
        dm_be     = cpu_gnt ? w_cpu_be : (dbg_gnt ? 4'b1111 : 4'b0000);
        dm_we     = (cpu_gnt & cpu_we & ~w_cpu_mis) | (dbg_gnt & dbg_we);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve     <= '0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_ld_size    <= SZ_WORD;
            r_ld_off     <= 2'b00;
            r_ld_sext    <= 1'b0;
            r_cpu_word   <= 32'h0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= 32'h0;
        end else begin
            if (dbg_req && !dbg_gnt) begin
                if (r_starve != c_STARVE) r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end

            r_cpu_rvalid <= cpu_gnt;
            r_cpu_err    <= cpu_gnt & w_cpu_mis;
            if (cpu_gnt) begin
                r_ld_size  <= cpu_size;
                r_ld_off   <= cpu_addr[1:0];
                r_ld_sext  <= cpu_sext;
                // A zero word makes the extracted result zero for misaligned accesses.
                r_cpu_word <= w_cpu_mis ? 32'h0 : dm_dout;
            end

            r_dbg_rvalid <= dbg_gnt;
            if (dbg_gnt) r_dbg_rdata <= dm_dout;
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_err    = r_cpu_err;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;

endmodule
`default_nettype wire
